uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single UART transmitter between N_REQ response sources, e.g. command
//   acks, APU status and memory readback. Grants whole packets: once granted, a
//   requester keeps the transmitter until it sends a byte flagged last. Sits between
//   the host command processor's responders and the UART TX serializer.
//   A stalled requester is evicted by a watchdog so the host link cannot hang.
// PARAMETERS
//   N_REQ           4       number of requesters, legal range 2..8
//   TIMEOUT_CYCLES  200000  idle cycles allowed mid-packet before the grant is revoked
// PORTS
//   clock        in   1        system clock
//   reset        in   1        synchronous, active-high
//   req          in   N_REQ    requester i wants the transmitter (level)
//   req_byte     in   8*N_REQ  byte of requester i in bits [8i+7:8i]
//   req_valid    in   N_REQ    req_byte[i] is valid
//   req_last     in   N_REQ    req_byte[i] is the final byte of its packet
//   req_ready    out  N_REQ    byte accepted when req_valid[i] & req_ready[i]
//   grant        out  N_REQ    one-hot, registered; requester that owns the transmitter
//   tx_byte      out  8        byte handed to the UART serializer
//   tx_start     out  1        one-cycle pulse: serializer loads tx_byte
//   tx_busy      in   1        serializer busy; rises the cycle after tx_start
//   timeout_err  out  1        one-cycle pulse: a grant was revoked by the watchdog
// BEHAVIOUR
//   Reset values: grant=0, tx_byte=0, tx_start=0, timeout_err=0, state=IDLE,
//     wdog=0, last_grant=N_REQ-1, so requester 0 has first priority after reset.
//   req_ready[i] = grant[i] & ~tx_busy & ~tx_start. This is combinational from registers.
//   States:
//     IDLE: if |req, pick the first i with req[i], searching round-robin from
//       last_grant+1 with wrap at N_REQ. Set grant to one-hot(i), wdog=0, go to GRANT.
//       If req=0, stay in IDLE.
//     GRANT: on accept (req_valid[g] & req_ready[g]), next cycle tx_byte=req_byte[g],
//       tx_start=1 for exactly 1 cycle, and wdog=0.
//       If the accepted byte has req_last[g]=1, go to RELEASE.
//       Otherwise, when no accept and ~tx_busy & ~tx_start, wdog increments.
//       If wdog reaches TIMEOUT_CYCLES-1 with no accept, set timeout_err=1 for 1 cycle,
//       grant=0, last_grant=g, and go to IDLE.
//     RELEASE: wait until ~tx_busy & ~tx_start, so the last byte is on the wire.
//       Then set grant=0, last_grant=g, and go to IDLE.
//   Latency: req to grant = 1 cycle from IDLE. Accept to tx_start = 1 cycle.
//     There is at least 1 IDLE cycle between consecutive packets.
//   Throughput: at most 1 byte per serializer frame; tx_busy gates every byte.
//   Dropping req mid-packet does not release the grant. Only last or timeout releases it.
//   req_valid/req_last from ungranted requesters are ignored.
//   Simultaneous requests: round-robin; the holder just released has lowest priority.
//   A 1-byte packet (valid & last on the first accept) is legal.
//   Timeout and accept in the same cycle: the accept wins and wdog clears.
//   Reset mid-packet: everything returns to reset values at once. tx_start is never
//     asserted on the reset cycle. A byte already in the serializer is not recalled.
//   wdog width = $clog2(TIMEOUT_CYCLES+1). Requester index width = $clog2(N_REQ).
// STRUCTURE
//   Shared package (uart_defs): state encodings ARB_IDLE/ARB_GRANT/ARB_RELEASE,
//     UART_BYTE_W=8, default TIMEOUT_CYCLES.
//   One sub-module: rr_priority_pick. Combinational round-robin search of req starting
//     after last_grant; outputs one-hot plus index. It is reused by later arbiters.
//   The top level holds the FSM, byte register, watchdog and request mux.
// TESTING
//   Single requester: req[1]=1, 3 bytes 0xA5,0x5A,0x3C (last on 0x3C), tx_busy 10
//     cycles per byte -> 3 tx_start pulses in order, grant[1] held, then grant=0.
//   Contention: req=4'b1111 held, each requester sends a 1-byte packet i*0x11 ->
//     order 0x00,0x11,0x22,0x33, then wraps to 0x00.
//   Fairness: requester 0 re-requests immediately after its last byte while req[2]=1 ->
//     requester 2 is granted next.
//   Watchdog: TIMEOUT_CYCLES=16, grant[3] sends 1 byte then stalls -> timeout_err pulse
//     16 cycles after tx_busy falls; grant=0; requester 0 is granted next if it requests.
//   Reset mid-packet: reset for 1 cycle during GRANT -> grant=0 and tx_start=0 next
//     cycle; requester 0 wins the next contention.
//   Backpressure: req_valid held high while tx_busy=1 -> req_ready=0 and no extra
//     tx_start; exactly one tx_start per accepted byte.

Source files
------------

// File: rtl/uart_defs.sv
// uart_defs: shared UART arbiter encodings and defaults
package uart_defs;
    localparam int UART_BYTE_W = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 200000;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams, grant and serializer handshake
interface uart_tx_arbiter_if import uart_defs::*; #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]             req, req_valid, req_last, req_ready, grant;
    logic [UART_BYTE_W*N_REQ-1:0] req_byte;
    logic [UART_BYTE_W-1:0]       tx_byte;
    logic                         tx_start, tx_busy, timeout_err;
    modport master (output req, req_byte, req_valid, req_last, tx_busy,
                    input req_ready, grant, tx_byte, tx_start, timeout_err);
    modport slave (input req, req_byte, req_valid, req_last, tx_busy,
                   output req_ready, grant, tx_byte, tx_start, timeout_err);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: round-robin search of req starting after last, one-hot plus index
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] one_hot,
    output logic [IW-1:0]    idx
);
    int j;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx = '0;
        j = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(last) + k) % N_REQ;
            if (req[IW'(j)]) idx = IW'(j);
        end
        one_hot = (|req) ? N_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter
// with a mid-packet stall watchdog.
module uart_tx_arbiter import uart_defs::*; #(
    parameter int N_REQ = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic              clock,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    arb_state_t       state;
    logic [IW-1:0]    g, last_grant, pick_idx;
    logic [N_REQ-1:0] pick_one_hot;
    logic [WW-1:0]    wdog;
    logic             idle, accept;
    assign idle = ~bus.tx_busy & ~bus.tx_start;
    assign bus.req_ready = bus.grant & {N_REQ{idle}};
    assign accept = (state == ARB_GRANT) && bus.req_valid[g] && bus.req_ready[g];
    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req(bus.req), .last(last_grant), .one_hot(pick_one_hot), .idx(pick_idx)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ARB_IDLE;
            bus.grant       <= '0;
            bus.tx_byte     <= '0;
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
            wdog            <= '0;
            g               <= '0;
            last_grant      <= IW'(N_REQ - 1);
        end else begin
            bus.tx_start    <= 1'b0;
            bus.timeout_err <= 1'b0;
            case (state)
                ARB_IDLE:
                    if (|bus.req) begin
                        bus.grant <= pick_one_hot;
                        g         <= pick_idx;
                        wdog      <= '0;
                        state     <= ARB_GRANT;
                    end
                ARB_GRANT:
                    // An accept always beats the watchdog expiring in the same cycle.
                    if (accept) begin
                        bus.tx_byte  <= bus.req_byte[g*UART_BYTE_W +: UART_BYTE_W];
                        bus.tx_start <= 1'b1;
                        wdog         <= '0;
                        if (bus.req_last[g]) state <= ARB_RELEASE;
                    end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
                        bus.timeout_err <= 1'b1;
                        bus.grant       <= '0;
                        last_grant      <= g;
                        state           <= ARB_IDLE;
                    end else if (idle) begin
                        wdog <= wdog + 1'b1;
                    end
                ARB_RELEASE:
                    if (idle) begin
                        bus.grant  <= '0;
                        last_grant <= g;
                        state      <= ARB_IDLE;
                    end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule
